// File: rtl/ibex_probe_status_gen_if.sv
// Probe link bundle between the Ibex core-side status generator and the bench.
// Ports (by modport):
//   slave  - status generator: consumes probe controls and core events, drives core controls and probe status
//   master - bench/probe side: the mirror image of slave
interface ibex_probe_status_gen_if #(
    parameter int unsigned CNT_W = 8
);
    // probe controls
    logic             fetch_enable_i;
    logic             debug_req_i;
    // core events
    logic             wfi_retire_i;
    logic             irq_pending_i;
    logic             ecall_retire_i;
    logic             alert_minor_ev_i;
    logic             alert_major_ev_i;
    logic             debug_ack_i;
    // controls back to the core
    logic             core_fetch_en_o;
    logic             core_debug_req_o;
    // probe status
    logic             core_sleep_o;
    logic             ecall_o;
    logic             alert_minor_o;
    logic             alert_major_o;
    logic [CNT_W-1:0] minor_cnt_o;

    modport slave (
        input  fetch_enable_i, debug_req_i, wfi_retire_i, irq_pending_i,
               ecall_retire_i, alert_minor_ev_i, alert_major_ev_i, debug_ack_i,
        output core_fetch_en_o, core_debug_req_o, core_sleep_o, ecall_o,
               alert_minor_o, alert_major_o, minor_cnt_o
    );

    modport master (
        output fetch_enable_i, debug_req_i, wfi_retire_i, irq_pending_i,
               ecall_retire_i, alert_minor_ev_i, alert_major_ev_i, debug_ack_i,
        input  core_fetch_en_o, core_debug_req_o, core_sleep_o, ecall_o,
               alert_minor_o, alert_major_o, minor_cnt_o
    );
endinterface

// File: rtl/ibex_probe_status_gen.sv
// Core-side end of the test probe link.
// Runs the sleep FSM (RUN/DRAIN/SLEEP/WAKE), holds debug requests until the
// core acknowledges them, stretches ecall retires and conditions alerts.
// Ports:
//   clk    - single clock, rising edge
//   rst_ni - synchronous reset, active-low
//   bus    - probe link bundle (slave side), see ibex_probe_status_gen_if
// All outputs are registered; there is no combinational input-to-output path.
module ibex_probe_status_gen #(
    parameter int unsigned DRAIN_CYCLES = 4,
    parameter int unsigned ECALL_HOLD   = 2,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                    clk,
    input  logic                    rst_ni,
    ibex_probe_status_gen_if.slave  bus
);
    localparam int unsigned DRN_W   = 4;
    localparam int unsigned ECALL_W = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        SLEEP = 2'd2,
        WAKE  = 2'd3
    } state_e;

    state_e             state, state_next;
    logic [DRN_W-1:0]   drain_cnt, drain_cnt_next;
    logic [ECALL_W-1:0] ecall_cnt, ecall_cnt_next;
    logic [CNT_W-1:0]   minor_cnt, minor_cnt_next;
    logic               debug_req_q;
    logic               debug_pending, debug_pending_next;
    logic               debug_edge;
    logic               wake_req;
    logic               fetch_en, sleep, ecall, alert_minor, alert_major;

    // Next-state and next-value logic for FSM, debug handshake and counters
    always_comb begin
        state_next         = state;
        drain_cnt_next     = drain_cnt;
        ecall_cnt_next     = ecall_cnt;
        minor_cnt_next     = minor_cnt;
        debug_edge         = bus.debug_req_i & ~debug_req_q;
        debug_pending_next = debug_pending;
        wake_req           = bus.irq_pending_i | debug_pending;

        unique case (state)
            RUN: begin
                if (bus.wfi_retire_i) begin
                    // A one-cycle drain means sleep is reached on the very next cycle
                    if (DRAIN_CYCLES <= 1) begin
                        state_next = SLEEP;
                    end else begin
                        state_next     = DRAIN;
                        drain_cnt_next = DRN_W'(DRAIN_CYCLES - 1);
                    end
                end
            end
            DRAIN: begin
                if (wake_req) begin
                    state_next = RUN;
                end else begin
                    drain_cnt_next = drain_cnt - DRN_W'(1);
                    // Counter reaching zero lands exactly DRAIN_CYCLES after the wfi
                    if (drain_cnt <= DRN_W'(1)) begin
                        state_next = SLEEP;
                    end
                end
            end
            SLEEP: begin
                if (wake_req) begin
                    state_next = WAKE;
                end
            end
            WAKE: begin
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase

        // Ack retires the current request; a coincident new edge re-arms it
        if (bus.debug_ack_i) begin
            debug_pending_next = debug_edge;
        end else if (debug_edge) begin
            debug_pending_next = 1'b1;
        end

        // Each retire (re)loads the full hold time
        if (bus.ecall_retire_i) begin
            ecall_cnt_next = ECALL_W'(ECALL_HOLD);
        end else if (ecall_cnt != '0) begin
            ecall_cnt_next = ecall_cnt - ECALL_W'(1);
        end

        // Saturating count, never wraps
        if (bus.alert_minor_ev_i && (minor_cnt != '1)) begin
            minor_cnt_next = minor_cnt + CNT_W'(1);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_ni) begin
            state         <= RUN;
            drain_cnt     <= '0;
            ecall_cnt     <= '0;
            minor_cnt     <= '0;
            debug_req_q   <= 1'b0;
            debug_pending <= 1'b0;
            fetch_en      <= 1'b0;
            sleep         <= 1'b0;
            ecall         <= 1'b0;
            alert_minor   <= 1'b0;
            alert_major   <= 1'b0;
        end else begin
            state         <= state_next;
            drain_cnt     <= drain_cnt_next;
            ecall_cnt     <= ecall_cnt_next;
            minor_cnt     <= minor_cnt_next;
            debug_req_q   <= bus.debug_req_i;
            debug_pending <= debug_pending_next;
            fetch_en      <= bus.fetch_enable_i & (state != SLEEP);
            sleep         <= (state_next == SLEEP);
            ecall         <= (ecall_cnt_next != '0);
            alert_minor   <= bus.alert_minor_ev_i;
            alert_major   <= alert_major | bus.alert_major_ev_i;
        end
    end

    assign bus.core_fetch_en_o  = fetch_en;
    assign bus.core_debug_req_o = debug_pending;
    assign bus.core_sleep_o     = sleep;
    assign bus.ecall_o          = ecall;
    assign bus.alert_minor_o    = alert_minor;
    assign bus.alert_major_o    = alert_major;
    assign bus.minor_cnt_o      = minor_cnt;

endmodule

// File: tb/tb_ibex_probe_status_gen.sv
// Directed self-checking bench for ibex_probe_status_gen (default parameters).
// Inputs are driven 1 time unit after each rising edge; outputs are sampled
// at the same point, so "cycle n" is the interval following edge n.
module tb_ibex_probe_status_gen;
    localparam int unsigned CNT_W = 8;

    logic clk;
    logic rst_ni;
    int   checks;
    int   failures;
    int   pulses;
    int   early_sleep;

    ibex_probe_status_gen_if #(.CNT_W(CNT_W)) bus ();

    ibex_probe_status_gen #(
        .DRAIN_CYCLES (4),
        .ECALL_HOLD   (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk    (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.fetch_enable_i   = 1'b0;
        bus.debug_req_i      = 1'b0;
        bus.wfi_retire_i     = 1'b0;
        bus.irq_pending_i    = 1'b0;
        bus.ecall_retire_i   = 1'b0;
        bus.alert_minor_ev_i = 1'b0;
        bus.alert_major_ev_i = 1'b0;
        bus.debug_ack_i      = 1'b0;
    endtask

    task automatic scramble_inputs();
        logic [7:0] r;
        r = 8'($urandom);
        bus.fetch_enable_i   = r[0];
        bus.debug_req_i      = r[1];
        bus.wfi_retire_i     = r[2];
        bus.irq_pending_i    = r[3];
        bus.ecall_retire_i   = r[4];
        bus.alert_minor_ev_i = r[5];
        bus.alert_major_ev_i = r[6];
        bus.debug_ack_i      = r[7];
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({bus.core_fetch_en_o, bus.core_debug_req_o, bus.core_sleep_o,
                    bus.ecall_o, bus.alert_minor_o, bus.alert_major_o, bus.minor_cnt_o});
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        rst_ni   = 1'b0;
        clear_inputs();

        // Reset with inputs toggling: outputs stay 0, including first cycle after release
        for (int i = 0; i < 6; i++) begin
            scramble_inputs();
            tick();
            check("reset_outs", all_outs(), 32'h0);
        end
        rst_ni = 1'b1;
        scramble_inputs();
        check("release_outs", all_outs(), 32'h0);
        clear_inputs();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        check("clean_reset", all_outs(), 32'h0);

        // Fetch enable passes through with one cycle latency
        bus.fetch_enable_i = 1'b1;
        tick();
        check("fetch_en_on", 32'(bus.core_fetch_en_o), 32'd1);

        // WFI at t0 -> sleep from t0+4
        bus.wfi_retire_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            bus.wfi_retire_i = 1'b0;
            check($sformatf("sleep_t0p%0d", k), 32'(bus.core_sleep_o), 32'(k == 4));
        end
        tick();
        check("sleep_fetch_off", 32'(bus.core_fetch_en_o), 32'd0);
        check("sleep_held", 32'(bus.core_sleep_o), 32'd1);
        // irq at t1 -> sleep low t1+1, fetch back t1+2
        bus.irq_pending_i = 1'b1;
        tick();
        bus.irq_pending_i = 1'b0;
        check("wake_sleep_low", 32'(bus.core_sleep_o), 32'd0);
        check("wake_fetch_still_off", 32'(bus.core_fetch_en_o), 32'd0);
        tick();
        check("wake_fetch_on", 32'(bus.core_fetch_en_o), 32'd1);

        // WFI cancelled by irq at t0+2: sleep never asserts
        tick();
        bus.wfi_retire_i = 1'b1;
        tick();
        bus.wfi_retire_i = 1'b0;
        tick();
        bus.irq_pending_i = 1'b1;
        early_sleep = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            bus.irq_pending_i = 1'b0;
            early_sleep += 32'(bus.core_sleep_o);
        end
        check("cancel_no_sleep", 32'(early_sleep), 32'd0);
        // Back in RUN: a fresh wfi sleeps after exactly four cycles
        bus.wfi_retire_i = 1'b1;
        tick();
        bus.wfi_retire_i = 1'b0;
        tick();
        tick();
        check("rerun_sleep_t3", 32'(bus.core_sleep_o), 32'd0);
        tick();
        check("rerun_sleep_t4", 32'(bus.core_sleep_o), 32'd1);
        bus.irq_pending_i = 1'b1;
        tick();
        bus.irq_pending_i = 1'b0;
        tick();
        tick();

        // Debug: rise at t0, drop t0+2, second rise t0+3, ack t0+5
        bus.debug_req_i = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("dbg_t0p%0d", k), 32'(bus.core_debug_req_o), 32'(k <= 5));
            bus.debug_req_i = (k != 2);
            bus.debug_ack_i = (k == 5);
        end
        bus.debug_req_i = 1'b0;
        bus.debug_ack_i = 1'b0;
        tick();
        // Ack coincident with a new rising edge re-arms the request
        bus.debug_req_i = 1'b1;
        tick();
        check("dbg_rearm_set", 32'(bus.core_debug_req_o), 32'd1);
        bus.debug_req_i = 1'b0;
        tick();
        bus.debug_req_i = 1'b1;
        bus.debug_ack_i = 1'b1;
        tick();
        bus.debug_ack_i = 1'b0;
        check("dbg_ack_edge_rearm", 32'(bus.core_debug_req_o), 32'd1);
        bus.debug_ack_i = 1'b1;
        tick();
        bus.debug_ack_i = 1'b0;
        check("dbg_ack_clear", 32'(bus.core_debug_req_o), 32'd0);
        bus.debug_req_i = 1'b0;
        tick();

        // Single ecall: high two cycles
        bus.ecall_retire_i = 1'b1;
        tick();
        bus.ecall_retire_i = 1'b0;
        check("ecall1_t1", 32'(bus.ecall_o), 32'd1);
        tick();
        check("ecall1_t2", 32'(bus.ecall_o), 32'd1);
        tick();
        check("ecall1_t3", 32'(bus.ecall_o), 32'd0);
        // Back-to-back ecalls extend the hold
        bus.ecall_retire_i = 1'b1;
        tick();
        check("ecall2_t1", 32'(bus.ecall_o), 32'd1);
        tick();
        bus.ecall_retire_i = 1'b0;
        check("ecall2_t2", 32'(bus.ecall_o), 32'd1);
        tick();
        check("ecall2_t3", 32'(bus.ecall_o), 32'd1);
        tick();
        check("ecall2_t4", 32'(bus.ecall_o), 32'd0);

        // 300 minor events: counter saturates at 255, every event pulses
        pulses = 0;
        for (int i = 0; i < 300; i++) begin
            bus.alert_minor_ev_i = 1'b1;
            tick();
            pulses += 32'(bus.alert_minor_o);
            if (i == 0) check("minor_first_pulse", 32'(bus.alert_minor_o), 32'd1);
            if (i == 9) check("minor_cnt_10", 32'(bus.minor_cnt_o), 32'd10);
            bus.alert_minor_ev_i = 1'b0;
            tick();
            pulses += 32'(bus.alert_minor_o);
        end
        check("minor_pulses", 32'(pulses), 32'd300);
        check("minor_cnt_sat", 32'(bus.minor_cnt_o), 32'd255);

        // Major alert is sticky and leaves the FSM alone
        check("major_before", 32'(bus.alert_major_o), 32'd0);
        bus.alert_major_ev_i = 1'b1;
        tick();
        bus.alert_major_ev_i = 1'b0;
        check("major_set", 32'(bus.alert_major_o), 32'd1);
        for (int k = 0; k < 5; k++) tick();
        check("major_sticky", 32'(bus.alert_major_o), 32'd1);
        check("major_fsm_run", 32'({bus.core_sleep_o, bus.core_fetch_en_o}), 32'd1);
        rst_ni = 1'b0;
        tick();
        check("major_reset", 32'(bus.alert_major_o), 32'd0);
        check("final_reset_outs", all_outs(), 32'h0);
        rst_ni = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
